// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder.
// Holds the set-2 scancode constants the decoder acts on, the prefix FSM
// state type with its encodings, and the bit positions inside kbsig.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;  // left Ctrl plain, right Ctrl after E0
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_RIGHT  = 8'h74;  // arrows are E0-prefixed
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;

  typedef logic [1:0] pfx_state_t;
  localparam pfx_state_t ST_IDLE = 2'd0;
  localparam pfx_state_t ST_E0   = 2'd1;
  localparam pfx_state_t ST_F0   = 2'd2;
  localparam pfx_state_t ST_E0F0 = 2'd3;

  localparam int unsigned KB_SHIFT = 0;
  localparam int unsigned KB_CAPS  = 1;
  localparam int unsigned KB_CTRL  = 3;
  localparam int unsigned KB_RIGHT = 5;
  localparam int unsigned KB_LEFT  = 6;
  localparam int unsigned KB_DOWN  = 7;
  localparam int unsigned KB_UP    = 8;
  localparam int unsigned KB_BKSP  = 9;

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational scancode (set 2) to ASCII translation.
// Ports:
//   scancode in 8 : make code, already stripped of prefixes
//   shift    in 1 : either Shift key held
//   caps     in 1 : Caps Lock state
//   ascii    out 8: translated character (0 when unmapped)
//   mapped   out 1: scancode has a character
// Letters are upper case when exactly one of shift/caps is active.
module ps2_scan_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       mapped
);

  logic [7:0] lower;
  logic       is_letter;

  always_comb begin
    lower     = '0;
    is_letter = 1'b0;
    ascii     = '0;
    mapped    = 1'b1;
    case (scancode)
      8'h1C: begin lower = 8'h61; is_letter = 1'b1; end
      8'h32: begin lower = 8'h62; is_letter = 1'b1; end
      8'h21: begin lower = 8'h63; is_letter = 1'b1; end
      8'h23: begin lower = 8'h64; is_letter = 1'b1; end
      8'h24: begin lower = 8'h65; is_letter = 1'b1; end
      8'h2B: begin lower = 8'h66; is_letter = 1'b1; end
      8'h34: begin lower = 8'h67; is_letter = 1'b1; end
      8'h33: begin lower = 8'h68; is_letter = 1'b1; end
      8'h43: begin lower = 8'h69; is_letter = 1'b1; end
      8'h3B: begin lower = 8'h6A; is_letter = 1'b1; end
      8'h42: begin lower = 8'h6B; is_letter = 1'b1; end
      8'h4B: begin lower = 8'h6C; is_letter = 1'b1; end
      8'h3A: begin lower = 8'h6D; is_letter = 1'b1; end
      8'h31: begin lower = 8'h6E; is_letter = 1'b1; end
      8'h44: begin lower = 8'h6F; is_letter = 1'b1; end
      8'h4D: begin lower = 8'h70; is_letter = 1'b1; end
      8'h15: begin lower = 8'h71; is_letter = 1'b1; end
      8'h2D: begin lower = 8'h72; is_letter = 1'b1; end
      8'h1B: begin lower = 8'h73; is_letter = 1'b1; end
      8'h2C: begin lower = 8'h74; is_letter = 1'b1; end
      8'h3C: begin lower = 8'h75; is_letter = 1'b1; end
      8'h2A: begin lower = 8'h76; is_letter = 1'b1; end
      8'h1D: begin lower = 8'h77; is_letter = 1'b1; end
      8'h22: begin lower = 8'h78; is_letter = 1'b1; end
      8'h35: begin lower = 8'h79; is_letter = 1'b1; end
      8'h1A: begin lower = 8'h7A; is_letter = 1'b1; end
      8'h45: ascii = shift ? 8'h29 : 8'h30;  // ')' / '0'
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = shift ? 8'h2A : 8'h38;  // '*' / '8'
      8'h46: ascii = shift ? 8'h28 : 8'h39;  // '(' / '9'
      SC_SPACE: ascii = 8'h20;
      SC_ENTER: ascii = 8'h0D;
      8'h4E: ascii = 8'h2D;
      8'h4A: ascii = 8'h2F;
      8'h55: ascii = shift ? 8'h2B : 8'h3D;  // '+' / '='
      default: mapped = 1'b0;
    endcase
    if (is_letter) ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard front end: synchronizes the raw PS/2 lines, deserializes
// 11-bit frames, tracks E0/F0 prefixes and modifier/arrow state, and emits
// one ASCII event per mapped key press.
// Ports:
//   clk       in 1  : system clock
//   clrn      in 1  : asynchronous active-low reset
//   ps2_clk   in 1  : raw PS/2 clock (asynchronous)
//   ps2_data  in 1  : raw PS/2 data (asynchronous)
//   ascii_out out 8 : last accepted character, held between events
//   out_valid out 1 : one-cycle pulse qualifying ascii_out
//   kbsig     out 16: shift/caps/ctrl/arrow levels, backspace pulse
//   frame_err out 1 : one-cycle pulse on a rejected frame
// Pipeline from the clk edge that first sees ps2_clk low at the stop bit:
// two sync stages, shift-in, frame check, then the output/FSM register,
// so events appear on the fourth edge after it.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  ascii_out,
  output logic        out_valid,
  output logic [15:0] kbsig,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  // clk_sync[1:0] is the synchronizer, clk_sync[2] the previous synced value
  logic [2:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        fall;

  logic [3:0]  bit_cnt;
  logic [10:0] shreg;
  logic [TW-1:0] idle_cnt;
  logic        frame_done;
  logic        frame_ok;

  logic        byte_stb;
  logic        err_stb;
  logic [7:0]  byte_q;

  pfx_state_t  state;
  pfx_state_t  nxt_state;
  logic        do_make;
  logic        do_break;
  logic        ext;

  logic        lshift, rshift, lctrl, rctrl;
  logic        caps_q, caps_held;
  logic [3:0]  arrows;  // right, left, down, up
  logic        bksp_pulse;
  logic        shift_lvl;
  logic [7:0]  map_ascii;
  logic        map_ok;

  // Idle-high reset values keep a fall from being seen right after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall = clk_sync[2] & ~clk_sync[1];

  // An edge resets the idle counter even in the cycle the timeout would fire.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fall) begin
        shreg    <= {data_sync[1], shreg[10:1]};
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // shreg[0]=start, [8:1]=data, [9]=parity, [10]=stop
  assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      byte_q   <= '0;
    end else begin
      byte_stb <= frame_done & frame_ok;
      err_stb  <= frame_done & ~frame_ok;
      if (frame_done) byte_q <= shreg[8:1];
    end
  end

  always_comb begin
    nxt_state = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    ext       = 1'b0;
    if (err_stb) begin
      nxt_state = ST_IDLE;
    end else if (byte_stb) begin
      case (state)
        ST_IDLE: begin
          if (byte_q == SC_E0)      nxt_state = ST_E0;
          else if (byte_q == SC_F0) nxt_state = ST_F0;
          else                      do_make   = 1'b1;
        end
        ST_E0: begin
          if (byte_q == SC_F0) begin
            nxt_state = ST_E0F0;
          end else begin
            do_make   = 1'b1;
            ext       = 1'b1;
            nxt_state = ST_IDLE;
          end
        end
        ST_F0: begin
          do_break  = 1'b1;
          nxt_state = ST_IDLE;
        end
        default: begin
          do_break  = 1'b1;
          ext       = 1'b1;
          nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  assign shift_lvl = lshift | rshift;

  ps2_scan_ascii u_scan (
    .scancode (byte_q),
    .shift    (shift_lvl),
    .caps     (caps_q),
    .ascii    (map_ascii),
    .mapped   (map_ok)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      lctrl      <= 1'b0;
      rctrl      <= 1'b0;
      caps_q     <= 1'b0;
      caps_held  <= 1'b0;
      arrows     <= '0;
      bksp_pulse <= 1'b0;
      ascii_out  <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= nxt_state;
      out_valid  <= 1'b0;
      bksp_pulse <= 1'b0;
      frame_err  <= err_stb;
      if (do_make || do_break) begin
        if (!ext) begin
          case (byte_q)
            SC_LSHIFT: lshift <= do_make;
            SC_RSHIFT: rshift <= do_make;
            SC_CTRL:   lctrl  <= do_make;
            SC_CAPS: begin
              // typematic repeats arrive while held and must not toggle
              if (do_make && !caps_held) caps_q <= ~caps_q;
              caps_held <= do_make;
            end
            SC_BKSP:   bksp_pulse <= do_make;
            default: ;
          endcase
        end else begin
          case (byte_q)
            SC_CTRL:  rctrl     <= do_make;
            SC_RIGHT: arrows[0] <= do_make;
            SC_LEFT:  arrows[1] <= do_make;
            SC_DOWN:  arrows[2] <= do_make;
            SC_UP:    arrows[3] <= do_make;
            default: ;
          endcase
        end
        if (do_make && !ext && map_ok) begin
          out_valid <= 1'b1;
          ascii_out <= map_ascii;
        end
      end
    end
  end

  always_comb begin
    kbsig           = '0;
    kbsig[KB_SHIFT] = shift_lvl;
    kbsig[KB_CAPS]  = caps_q;
    kbsig[KB_CTRL]  = lctrl | rctrl;
    kbsig[KB_RIGHT] = arrows[0];
    kbsig[KB_LEFT]  = arrows[1];
    kbsig[KB_DOWN]  = arrows[2];
    kbsig[KB_UP]    = arrows[3];
    kbsig[KB_BKSP]  = bksp_pulse;
  end

endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Receives raw PS/2 keyboard traffic, deserializes 11-bit frames, and tracks make/break/extended prefixes and modifier state. Emits one ASCII event per key press, plus a status vector. It is the producer side of the `ascii/valid/kbsig` interface consumed by the calculator text editor and sits between the board PS/2 pins and that block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 5000: idle clk cycles inside a frame before the bit counter is discarded (100 µs at 50 MHz).

Ports:
- `clk` in 1: system clock (50 MHz); all logic on rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `ascii_out` out 8: ASCII code of the last accepted key press; held between events.
- `out_valid` out 1: one-cycle pulse qualifying `ascii_out`.
- `kbsig` out 16: key status vector, defined under Operation.
- `frame_err` out 1: one-cycle pulse on a rejected frame.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A third register on `ps2_clk` provides falling-edge detection. Data is sampled on a detected falling edge.
- **Frame:** start bit = 0, 8 data bits LSB first, odd parity, stop bit = 1.
  - A valid frame yields one scancode byte.
  - A frame with a start, parity or stop violation is dropped, `frame_err` pulses, and the prefix FSM returns to IDLE.
- **Timeout:** if no falling edge arrives for `TIMEOUT_CYCLES` while bit count ≠ 0, the bit count resets to 0 silently. `frame_err` does not pulse.
- **Prefix FSM** (states IDLE, E0, F0, E0F0):
  - IDLE: 0xE0→E0; 0xF0→F0; any other byte is a normal make, then stay in IDLE.
  - E0: 0xF0→E0F0; any other byte is an extended make, then →IDLE.
  - F0: any byte is a normal break, then →IDLE.
  - E0F0: any byte is an extended break, then →IDLE.
- **Modifiers:**
  - Shift (0x12, 0x59) and Ctrl (0x14, E0 14) are held levels, set on make and cleared on break.
  - Caps Lock (0x58) toggles on make only when not already held, so typematic repeat does not toggle it.
- **Mapping:** done in `ps2_scan_ascii`. Letters are upper case iff Shift XOR Caps.
  - Digits '0'–'9'.
  - Space 0x29→0x20; Enter 0x5A→0x0D.
  - Keys 0x4E '-', 0x4A '/', 0x55 '=' (Shift: '+').
  - Shift+8 gives '*', Shift+9 gives '(', Shift+0 gives ')'.
- **Ctrl:** does not alter the ASCII code (Ctrl+D emits 0x64 with `kbsig[3]`=1).
- **Events:**
  - A mapped make, including typematic repeats, pulses `out_valid` with the new `ascii_out`.
  - Unmapped makes and all breaks produce no pulse.
- **kbsig bits:**
  - [0] Shift held; [1] Caps state; [3] Ctrl held.
  - [5] Right (E0 74), [6] Left (E0 6B), [7] Down (E0 72), [8] Up (E0 75): levels while held.
  - [9] one-cycle pulse on each Backspace (0x66) make; no `out_valid`.
  - All other bits are 0.

## Timing
- **Reset values:** `ascii_out`=0, `out_valid`=0, `kbsig`=0 (Caps off), `frame_err`=0, FSM=IDLE, bit count=0, timeout counter=0.
- **Latency:** `out_valid` / `kbsig[9]` / `frame_err` assert exactly 4 clk cycles after the first `clk` edge that samples raw `ps2_clk` low for the stop bit.
- **Modifier and arrow levels:** `kbsig` level bits update in that same cycle.
- **Pulse spacing:** at most one event per scancode, so consecutive pulses are ≥ 1 frame apart. No backpressure; the consumer must sample every pulse.
- **Reset mid-frame:** the partial frame is discarded and no event is emitted. The first falling edge after release is treated as a start bit.
- **Simultaneous events:** a timeout expiring in the same cycle as a falling edge is resolved in favour of the edge.

## Structure
- Package `ps2_pkg` holds:
  - scancode constants (E0, F0, modifiers, arrows, Backspace, Enter);
  - the prefix FSM state typedef;
  - `kbsig` bit-index localparams.
- Sub-module `ps2_scan_ascii`: combinational `{scancode, shift, caps}` → `{ascii, mapped}`.
- Frame receiver, timeout, FSM and modifier registers live in the top module.

## Test plan
- Frames 1C, F0 1C → one `out_valid` with `ascii_out`=0x61 four cycles after the first stop bit; no pulse for the break.
- 12, 55, F0 55, F0 12 → `ascii_out`=0x2B; `kbsig[0]` high between the first and last frames, then 0.
- 14, 23 → `ascii_out`=0x64 with `kbsig[3]`=1 at the pulse; 58, F0 58, 1C → 0x41 and `kbsig[1]`=1.
- E0 75 → `kbsig[8]`=1 with no `out_valid`; E0 F0 75 → `kbsig[8]`=0. 66 → `kbsig[9]` pulses for one cycle.
- Frame 0x45 with wrong parity → `frame_err` pulses, no event; the next good 0x45 → 0x30.
- `ps2_clk` stalls after 5 bits for more than 5000 cycles, then a full 0x16 frame → one event 0x31. `clrn` low mid-frame → all outputs 0 and no event.
